uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART serial transmitter. It is the transmit-side counterpart to the RX path and runs off the same 10 MHz sys_clk at 115200 baud (87 clocks per bit). It accepts one parallel byte per valid/ready handshake and serialises it as start, data (LSB first), optional parity and stop bit(s). Bit timing comes from an internal per-bit clock counter, not a divided clock, so the whole block stays in the single sys_clk domain.

Parameters:
CLK_PER_BIT, 87, sys_clk cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
tx_data  input  DATA_BITS  byte to send; sampled only on the accept edge.
tx_valid  input  1  request to send tx_data.
tx_ready  output  1  high only in IDLE; transfer occurs when tx_valid && tx_ready at a rising edge.
tx_serial  output  1  serial line; idles high.
tx_busy  output  1  high from the accept edge until the frame's last stop bit ends.
tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE, tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - Bit counter, data shift register and parity accumulator cleared.
  - A frame in progress is abandoned and is not resumed after reset releases.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- IDLE:
  - tx_serial = 1, tx_ready = 1.
  - On an edge with tx_valid = 1: latch tx_data into the shift register, go to START, drive tx_serial = 0, tx_ready = 0, tx_busy = 1.
- Bit timing:
  - The clock counter runs 0 .. CLK_PER_BIT-1 and wraps to 0.
  - Each bit holds tx_serial for exactly CLK_PER_BIT cycles.
  - The state or bit transition happens on the edge where the counter equals CLK_PER_BIT-1.
  - Counter width is clog2(CLK_PER_BIT), with a minimum of 1.
- START: send 0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - Send shift register bit 0, then shift right.
  - Accumulate XOR of the sent bits for parity.
  - After DATA_BITS bits, go to PARITY, or to STOP if PARITY = 0.
- PARITY: even sends XOR of the data bits; odd sends its complement.
- STOP:
  - Send 1 for STOP_BITS bit times.
  - On the final edge of the last stop bit: state = IDLE, tx_ready = 1, tx_busy = 0, tx_done = 1 for exactly that following cycle.
- Frame length, accept edge to the IDLE return edge: CLK_PER_BIT * (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- Back-to-back frames:
  - tx_valid held high is accepted on the first IDLE edge.
  - This gives exactly one sys_clk of idle-high between the last stop bit and the next start bit.
- Input handling outside IDLE:
  - tx_valid and tx_data are ignored while not in IDLE.
  - A change of tx_data mid-frame has no effect.
  - There is no queuing.
- tx_done and tx_valid in the same cycle: tx_ready is already 1, so the new byte is accepted on that edge.

Test Plan:
- Reset: assert reset for 3 cycles -> tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0; assert reset asynchronously mid-clock -> outputs change before the next edge.
- 8N1 at 87: send 0xA5 -> line low for 87 cycles, then bits 1,0,1,0,0,1,0,1 at 87 cycles each, then high for 87 cycles; tx_done pulses 870 cycles after the accept edge; tx_busy is high for exactly 870 cycles.
- Parity (CLK_PER_BIT = 4): send 0xA5 with PARITY = 2 -> parity bit 0; with PARITY = 1 -> parity bit 1; send 0x07 with PARITY = 2 -> parity bit 1; frame is 44 cycles.
- Back-to-back (CLK_PER_BIT = 4, tx_valid held high, bytes 0x55 then 0x0F) -> the second start bit begins exactly 1 cycle after the first frame's stop bit ends; both bytes are reconstructed correctly by the bench sampler.
- Mid-frame input changes (CLK_PER_BIT = 4): change tx_data to 0xFF and toggle tx_valid during the DATA bits of a 0x3C frame -> 0x3C is sent unchanged and no extra frame is started.
- Reset during DATA (CLK_PER_BIT = 4, STOP_BITS = 2): pulse reset at bit 3 -> tx_serial = 1 immediately; the next accepted byte 0x81 is sent as a complete frame with 2 stop bits (48 cycles).

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per valid/ready handshake as
// start bit, DATA_BITS data bits (LSB first), optional parity and
// STOP_BITS stop bits. Bit timing comes from a per-bit clock counter,
// so everything stays in the sys_clk domain and every output is a flop.
module uart_tx #(
    parameter int CLK_PER_BIT = 87,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   serial_q, serial_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bitEnd;

    assign bitEnd    = (cnt_q == CNT_LAST);
    assign tx_ready  = ready_q;
    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, otherwise advance only on the last cycle of a bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tx_valid) state_d = ST_START;
            ST_START: if (bitEnd) state_d = ST_DATA;
            ST_DATA:  if (bitEnd && bitIdx_q == DATA_LAST)
                          state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            ST_PAR:   if (bitEnd) state_d = ST_STOP;
            ST_STOP:  if (bitEnd && bitIdx_q == STOP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: bit-time counter, bit index, shift register and running parity.
    always_comb begin
        cnt_d    = '0;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        if (state_q == ST_IDLE) begin
            if (tx_valid) begin
                shift_d  = tx_data;
                parity_d = 1'b0;
                bitIdx_d = '0;
            end
        end else begin
            cnt_d = bitEnd ? '0 : cnt_q + CNT_W'(1);
            if (bitEnd) begin
                bitIdx_d = (state_d != state_q) ? 3'd0 : bitIdx_q + 3'd1;
                if (state_q == ST_DATA) begin
                    shift_d  = shift_q >> 1;
                    parity_d = parity_q ^ shift_q[0];
                end
            end
        end
    end

    // Output next values, derived from where the FSM lands so the flops change on the same edge.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            ST_IDLE:  serial_d = 1'b1;
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_d[0];
            ST_PAR:   serial_d = (PARITY == 2) ? parity_d : ~parity_d;
            ST_STOP:  serial_d = 1'b1;
            default:  serial_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    // Datapath and output registers with the line idling high out of reset.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Five instances cover the configurations of
// interest: 8N1 at 87 clocks/bit, even and odd parity at 4 clocks/bit,
// even parity with two stop bits at 4 clocks/bit, and plain 8N1 at 4.
module tb_uart_tx;

    logic       sysClk;
    logic       reset;
    logic [7:0] txData [5];
    logic [4:0] txValid;
    wire  [4:0] txReady;
    wire  [4:0] txSerial;
    wire  [4:0] txBusy;
    wire  [4:0] txDone;

    int testsRun;
    int testsFailed;

    uart_tx #(.CLK_PER_BIT(87), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut87 (
        .sys_clk(sysClk), .reset(reset), .tx_data(txData[0]), .tx_valid(txValid[0]),
        .tx_ready(txReady[0]), .tx_serial(txSerial[0]), .tx_busy(txBusy[0]), .tx_done(txDone[0])
    );

    uart_tx #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutEven (
        .sys_clk(sysClk), .reset(reset), .tx_data(txData[1]), .tx_valid(txValid[1]),
        .tx_ready(txReady[1]), .tx_serial(txSerial[1]), .tx_busy(txBusy[1]), .tx_done(txDone[1])
    );

    uart_tx #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutOdd (
        .sys_clk(sysClk), .reset(reset), .tx_data(txData[2]), .tx_valid(txValid[2]),
        .tx_ready(txReady[2]), .tx_serial(txSerial[2]), .tx_busy(txBusy[2]), .tx_done(txDone[2])
    );

    uart_tx #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutStop2 (
        .sys_clk(sysClk), .reset(reset), .tx_data(txData[3]), .tx_valid(txValid[3]),
        .tx_ready(txReady[3]), .tx_serial(txSerial[3]), .tx_busy(txBusy[3]), .tx_done(txDone[3])
    );

    uart_tx #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutFast (
        .sys_clk(sysClk), .reset(reset), .tx_data(txData[4]), .tx_valid(txValid[4]),
        .tx_ready(txReady[4]), .tx_serial(txSerial[4]), .tx_busy(txBusy[4]), .tx_done(txDone[4])
    );

    // 10 ns system clock
    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    // One comparison: count it, and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Offer a byte while the DUT is idle; returns 1 ns after the accept edge
    task automatic applyStimulus(input int d, input logic [7:0] data, input logic hold, input string tag);
        checkOutput($sformatf("%s_ready_before", tag), 16'(txReady[d]), 16'h1);
        txData[d]  = data;
        txValid[d] = 1'b1;
        tick(1);
        if (!hold) txValid[d] = 1'b0;
    endtask

    // Walk a whole frame from the accept edge: every bit must hold its level for cpb cycles
    // with busy high throughout, then the cycle after the final edge must show done/idle
    task automatic checkFrame(input int d, input int cpb, input logic [15:0] bits, input int nbits,
                              input logic disturb, input string tag);
        logic ctlOk;
        logic seen;
        ctlOk = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            seen = bits[k];
            for (int c = 0; c < cpb; c++) begin
                if (txSerial[d] !== bits[k]) seen = txSerial[d];
                if (txBusy[d] !== 1'b1 || txReady[d] !== 1'b0 || txDone[d] !== 1'b0) ctlOk = 1'b0;
                if (disturb && k >= 2 && k <= 6) begin
                    txData[d]  = 8'hFF;
                    txValid[d] = ~txValid[d];
                end
                if (disturb && k == 7) txValid[d] = 1'b0;
                tick(1);
            end
            checkOutput($sformatf("%s_bit%0d", tag, k), 16'(seen), 16'(bits[k]));
        end
        checkOutput($sformatf("%s_busy_during", tag), 16'(ctlOk), 16'h1);
        checkOutput($sformatf("%s_end_done_busy_ready_serial", tag),
                    16'({txDone[d], txBusy[d], txReady[d], txSerial[d]}), 16'b1011);
    endtask

    // The done pulse must last exactly one cycle
    task automatic checkEnd(input int d, input string tag);
        tick(1);
        checkOutput($sformatf("%s_after_done_busy_ready_serial", tag),
                    16'({txDone[d], txBusy[d], txReady[d], txSerial[d]}), 16'b0011);
    endtask

    // The line must stay idle (high, not busy) for n cycles
    task automatic idleWatch(input int d, input int n, input string tag);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (txSerial[d] !== 1'b1 || txBusy[d] !== 1'b0) ok = 1'b0;
            tick(1);
        end
        checkOutput(tag, 16'(ok), 16'h1);
    endtask

    // Directed sequence
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        txValid     = '0;
        for (int i = 0; i < 5; i++) txData[i] = 8'h00;

        // Reset held for three cycles: all lines idle high, ready, not busy
        tick(3);
        checkOutput("reset_serial", 16'(txSerial), 16'h1F);
        checkOutput("reset_ready",  16'(txReady),  16'h1F);
        checkOutput("reset_busy",   16'(txBusy),   16'h00);
        checkOutput("reset_done",   16'(txDone),   16'h00);
        reset = 1'b0;
        tick(2);

        // 8N1 at 87 clocks/bit: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 over 870 cycles
        applyStimulus(0, 8'hA5, 1'b0, "a5_8n1");
        checkFrame(0, 87, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, "a5_8n1");
        checkEnd(0, "a5_8n1");

        // Even parity on 0xA5 (four ones) -> parity bit 0, 44 cycles
        applyStimulus(1, 8'hA5, 1'b0, "a5_even");
        checkFrame(1, 4, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0, "a5_even");
        checkEnd(1, "a5_even");

        // Odd parity on 0xA5 -> parity bit 1
        applyStimulus(2, 8'hA5, 1'b0, "a5_odd");
        checkFrame(2, 4, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 1'b0, "a5_odd");
        checkEnd(2, "a5_odd");

        // Even parity on 0x07 (three ones) -> parity bit 1
        applyStimulus(1, 8'h07, 1'b0, "07_even");
        checkFrame(1, 4, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b0, "07_even");
        checkEnd(1, "07_even");

        // Back-to-back with valid held: exactly one idle-high cycle between frames
        applyStimulus(4, 8'h55, 1'b1, "b2b_first");
        txData[4] = 8'h0F;
        checkFrame(4, 4, 16'({1'b1, 8'h55, 1'b0}), 10, 1'b0, "b2b_first");
        tick(1);
        txValid[4] = 1'b0;
        checkFrame(4, 4, 16'({1'b1, 8'h0F, 1'b0}), 10, 1'b0, "b2b_second");
        checkEnd(4, "b2b_second");

        // Data forced to 0xFF and valid toggled mid-frame: 0x3C still goes out, nothing queued
        applyStimulus(4, 8'h3C, 1'b0, "midframe");
        checkFrame(4, 4, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b1, "midframe");
        checkEnd(4, "midframe");
        idleWatch(4, 12, "midframe_no_extra_frame");

        // Asynchronous reset during data bit 3 of a 0x00 frame (line low there)
        applyStimulus(3, 8'h00, 1'b0, "rst_mid");
        tick(17);
        checkOutput("rst_mid_line_low_before", 16'(txSerial[3]), 16'h0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_async_serial_ready_busy_done",
                    16'({txSerial[3], txReady[3], txBusy[3], txDone[3]}), 16'b1100);
        @(posedge sysClk);
        #1;
        reset = 1'b0;
        idleWatch(3, 60, "rst_mid_not_resumed");

        // After reset, 0x81 with even parity (0) and two stop bits: 48 cycles
        applyStimulus(3, 8'h81, 1'b0, "81_stop2");
        checkFrame(3, 4, 16'({2'b11, 1'b0, 8'h81, 1'b0}), 12, 1'b0, "81_stop2");
        checkEnd(3, "81_stop2");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
